img2col_weight: RTL and testbench

- Converts one convolution kernel stored in the weight BRAM into a densely packed img2col weight column.
- Source layout: one 128-bit word per kernel position; each word holds up to 8 input-channel lanes.
- Output: the flattened sequence (position-major, channel-minor) packed 8 elements per 128-bit word, written to a downstream buffer.
- Sits between the weight BRAM (blk_mem_gen_0-style simple dual-port, 1-cycle read latency, no output register) and the cube weight buffer.

---
 rtl/img2col_weight.sv | 184 ++++++++++++++++++
 tb/tb_img2col_weight.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img2col_weight.sv
// img2col_weight: unpacks one convolution kernel (one BRAM word per kernel
// position, C valid channel lanes each) into a dense position-major,
// channel-minor stream packed LANES elements per output word.
module img2col_weight #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int MAX_K  = 5
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    i2c_wgt_start,
  input  logic [3:0]              kernel_size,
  input  logic [LANES*DATA_W-1:0] wgt_in,
  input  logic [3:0]              valid_num,
  output logic                    i2c_ready,
  output logic [4:0]              wgt_rd_addr,
  output logic                    wgt_rd_en,
  output logic [4:0]              wgt_wr_addr,
  output logic                    wgt_wr_en,
  output logic [LANES*DATA_W-1:0] wgt_out,
  output logic [3:0]              num_valid
);

  localparam int WORD_W = LANES * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_UNPACK = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  state_t            state_q;
  logic [4:0]        kk_last_q;   // K*K-1, index of the last kernel position
  logic [2:0]        c_last_q;    // C-1, index of the last valid lane
  logic [4:0]        p_q;         // current kernel position
  logic [2:0]        c_q;         // current lane within the captured word
  logic [2:0]        f_q;         // pack slots already filled
  logic [4:0]        w_q;         // next output word address
  logic [WORD_W-1:0] word_q;      // captured BRAM word
  logic [WORD_W-1:0] pack_q;      // partially filled output word
  logic              ready_q;
  logic [4:0]        rd_addr_q;
  logic              rd_en_q;
  logic [4:0]        wr_addr_q;
  logic              wr_en_q;
  logic [WORD_W-1:0] out_q;
  logic [3:0]        nv_q;

  logic [DATA_W-1:0] lane_s;
  logic [WORD_W-1:0] pack_d;

  // Zero means 1; anything above MAX_K saturates at MAX_K. Returns K*K-1.
  function automatic logic [4:0] kk_last_of(input logic [3:0] k_raw);
    logic [2:0] k;
    logic [5:0] sq;
    if (k_raw == 4'd0) begin
      k = 3'd1;
    end else if (k_raw > 4'(MAX_K)) begin
      k = 3'(MAX_K);
    end else begin
      k = k_raw[2:0];
    end
    sq = {3'd0, k} * {3'd0, k};
    return 5'(sq - 6'd1);
  endfunction

  // Zero or more than LANES means all lanes are valid. Returns C-1.
  function automatic logic [2:0] c_last_of(input logic [3:0] c_raw);
    if ((c_raw == 4'd0) || (c_raw > 4'(LANES))) begin
      return 3'(LANES - 1);
    end else begin
      return 3'(c_raw - 4'd1);
    end
  endfunction

  // Select the current lane and drop it into the next free pack slot.
  always_comb begin
    lane_s = word_q[c_q*DATA_W +: DATA_W];
    pack_d = pack_q;
    pack_d[f_q*DATA_W +: DATA_W] = lane_s;
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kk_last_q <= 5'd0;
      c_last_q  <= 3'd0;
      p_q       <= 5'd0;
      c_q       <= 3'd0;
      f_q       <= 3'd0;
      w_q       <= 5'd0;
      word_q    <= '0;
      pack_q    <= '0;
      ready_q   <= 1'b1;
      rd_addr_q <= 5'd0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_en_q   <= 1'b0;
      out_q     <= '0;
      nv_q      <= 4'd0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i2c_wgt_start) begin
            kk_last_q <= kk_last_of(kernel_size);
            c_last_q  <= c_last_of(valid_num);
            p_q       <= 5'd0;
            f_q       <= 3'd0;
            w_q       <= 5'd0;
            pack_q    <= '0;
            ready_q   <= 1'b0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= 5'd0;
            state_q   <= S_FETCH;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          word_q  <= wgt_in;
          c_q     <= 3'd0;
          state_q <= S_UNPACK;
        end
        S_UNPACK: begin
          c_q <= c_q + 3'd1;
          if (f_q == 3'(LANES - 1)) begin
            out_q     <= pack_d;
            wr_en_q   <= 1'b1;
            wr_addr_q <= w_q;
            nv_q      <= 4'(LANES);
            w_q       <= w_q + 5'd1;
            f_q       <= 3'd0;
            pack_q    <= '0;
          end else begin
            pack_q <= pack_d;
            f_q    <= f_q + 3'd1;
          end
          if (c_q == c_last_q) begin
            if (p_q < kk_last_q) begin
              p_q       <= p_q + 5'd1;
              rd_en_q   <= 1'b1;
              rd_addr_q <= p_q + 5'd1;
              state_q   <= S_FETCH;
            end else begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // Unfilled slots are already zero because pack_q clears on each write.
          if (f_q != 3'd0) begin
            out_q     <= pack_q;
            wr_en_q   <= 1'b1;
            wr_addr_q <= w_q;
            nv_q      <= {1'b0, f_q};
          end
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign i2c_ready   = ready_q;
  assign wgt_rd_addr = rd_addr_q;
  assign wgt_rd_en   = rd_en_q;
  assign wgt_wr_addr = wr_addr_q;
  assign wgt_wr_en   = wr_en_q;
  assign wgt_out     = out_q;
  assign num_valid   = nv_q;

endmodule

// File: tb/tb_img2col_weight.sv
// Bench for img2col_weight: BRAM model, scoreboard of expected reads/writes,
// table of jobs plus hand-written timing, busy, reset and held-start cases.
module tb_img2col_weight;

  logic         clock;
  logic         rst_n;
  logic         start;
  logic [3:0]   k_in;
  logic [3:0]   c_in;
  logic [127:0] bram_q;
  logic         ready;
  logic [4:0]   rd_addr;
  logic         rd_en;
  logic [4:0]   wr_addr;
  logic         wr_en;
  logic [127:0] wout;
  logic [3:0]   nv;

  img2col_weight dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .i2c_wgt_start(start),
    .kernel_size  (k_in),
    .wgt_in       (bram_q),
    .valid_num    (c_in),
    .i2c_ready    (ready),
    .wgt_rd_addr  (rd_addr),
    .wgt_rd_en    (rd_en),
    .wgt_wr_addr  (wr_addr),
    .wgt_wr_en    (wr_en),
    .wgt_out      (wout),
    .num_valid    (nv)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]   addr;
    logic [127:0] data;
    logic [3:0]   nv;
  } wr_t;

  typedef struct {
    logic [3:0] k;
    logic [3:0] c;
    int         pat;
    int         exp_rd;
    int         exp_wr;
  } vec_t;

  logic [127:0] mem [32];
  logic [127:0] cap [32];
  logic [3:0]   cap_nv [32];
  wr_t          wr_q[$];
  logic [4:0]   rd_q[$];
  int           checks = 0;
  int           errors = 0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  vec_t         vecs [7];

  // Simple dual-port BRAM read port: one cycle latency, no output register.
  always @(posedge clock) begin
    if (rd_en) bram_q <= mem[rd_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop expected reads and writes as the DUT produces them.
  always @(negedge clock) begin
    wr_t e;
    logic [4:0] ea;
    if (rst_n) begin
      if (rd_en) begin
        rd_cnt++;
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got addr %0d, expected no read", rd_addr);
        end else begin
          ea = rd_q.pop_front();
          chk("rd_addr", 128'(rd_addr), 128'(ea));
        end
      end
      if (wr_en) begin
        wr_cnt++;
        cap[wr_addr] = wout;
        cap_nv[wr_addr] = nv;
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got addr %0d, expected no write", wr_addr);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", 128'(wr_addr), 128'(e.addr));
          chk("wr_data", wout, e.data);
          chk("wr_nv", 128'(nv), 128'(e.nv));
        end
      end
    end
  end

  task automatic fill(input int pat);
    for (int a = 0; a < 32; a++) begin
      mem[a] = '0;
      if (pat == 0) begin
        mem[a][15:0] = 16'(a + 1);
      end else begin
        for (int l = 0; l < 8; l++) mem[a][l*16 +: 16] = 16'(a*16 + l + 10);
      end
    end
  endtask

  // Reference model: flatten position-major, channel-minor, pack by 8.
  task automatic push_expected(input logic [3:0] kr, input logic [3:0] cr);
    int k, c, f, w;
    wr_t e;
    k = (kr == 4'd0) ? 1 : ((kr > 4'd5) ? 5 : int'(kr));
    c = ((cr == 4'd0) || (cr > 4'd8)) ? 8 : int'(cr);
    f = 0; w = 0; e.data = '0;
    for (int p = 0; p < k*k; p++) begin
      rd_q.push_back(5'(p));
      for (int l = 0; l < c; l++) begin
        e.data[f*16 +: 16] = mem[p][l*16 +: 16];
        f++;
        if (f == 8) begin
          e.addr = 5'(w); e.nv = 4'd8;
          wr_q.push_back(e);
          w++; f = 0; e.data = '0;
        end
      end
    end
    if (f > 0) begin
      e.addr = 5'(w); e.nv = 4'(f);
      wr_q.push_back(e);
    end
  endtask

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (ready) begin ok = 1'b1; break; end
    end
    chk(name, 128'(ok), 128'(1));
    @(negedge clock);
  endtask

  task automatic run_job(input logic [3:0] k, input logic [3:0] c, input int exp_rd, input int exp_wr);
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_expected(k, c);
    @(negedge clock);
    k_in = k; c_in = c; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("ready_low_after_start", 128'(ready), 128'(0));
    wait_ready("job_done");
    chk("job_reads", 128'(rd_cnt - rd0), 128'(exp_rd));
    chk("job_writes", 128'(wr_cnt - wr0), 128'(exp_wr));
    chk("scoreboard_empty", 128'(wr_q.size() + rd_q.size()), 128'(0));
  endtask

  initial begin
    int rd0, wr0, n;
    bit seen;
    vecs[0] = '{k: 4'd3, c: 4'd3, pat: 0, exp_rd: 9,  exp_wr: 4};
    vecs[1] = '{k: 4'd1, c: 4'd8, pat: 1, exp_rd: 1,  exp_wr: 1};
    vecs[2] = '{k: 4'd7, c: 4'd0, pat: 1, exp_rd: 25, exp_wr: 25};
    vecs[3] = '{k: 4'd2, c: 4'd5, pat: 1, exp_rd: 4,  exp_wr: 3};
    vecs[4] = '{k: 4'd0, c: 4'd9, pat: 1, exp_rd: 1,  exp_wr: 1};
    vecs[5] = '{k: 4'd4, c: 4'd3, pat: 0, exp_rd: 16, exp_wr: 6};
    vecs[6] = '{k: 4'd5, c: 4'd7, pat: 1, exp_rd: 25, exp_wr: 22};

    rst_n = 1'b0; start = 1'b0; k_in = 4'd0; c_in = 4'd0;
    fill(0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_rd_en", 128'(rd_en), 128'(0));
    chk("rst_wr_en", 128'(wr_en), 128'(0));
    chk("rst_num_valid", 128'(nv), 128'(0));
    chk("rst_rd_addr", 128'(rd_addr), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    @(negedge clock);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      fill(vecs[i].pat);
      run_job(vecs[i].k, vecs[i].c, vecs[i].exp_rd, vecs[i].exp_wr);
      if (i == 0) begin
        chk("main_w0", cap[0], {16'd0, 16'd3, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd1});
        chk("main_w1", cap[1], {16'd6, 16'd0, 16'd0, 16'd5, 16'd0, 16'd0, 16'd4, 16'd0});
        chk("main_w2", cap[2], {16'd0, 16'd0, 16'd8, 16'd0, 16'd0, 16'd7, 16'd0, 16'd0});
        chk("main_w3", cap[3], {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd9});
        chk("main_nv3", 128'(cap_nv[3]), 128'(3));
      end
    end

    // Timing: read strobe only in the cycle after acceptance, write 4 edges later.
    fill(1);
    push_expected(4'd1, 4'd1);
    @(negedge clock);
    k_in = 4'd1; c_in = 4'd1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("t_rd_en_cycle1", 128'(rd_en), 128'(1));
    @(posedge clock); #1;
    chk("t_rd_en_cycle2", 128'(rd_en), 128'(0));
    n = 1; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      n++;
      if (wr_en) begin seen = 1'b1; break; end
    end
    chk("t_wr_seen", 128'(seen), 128'(1));
    chk("t_wr_latency", 128'(n), 128'(4));
    wait_ready("t_done");

    // Busy: a second start mid-job is ignored.
    fill(0);
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_expected(4'd3, 4'd3);
    @(negedge clock);
    k_in = 4'd3; c_in = 4'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0; k_in = 4'd5; c_in = 4'd8;
    repeat (12) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_ready("busy_done");
    chk("busy_reads", 128'(rd_cnt - rd0), 128'(9));
    chk("busy_writes", 128'(wr_cnt - wr0), 128'(4));
    chk("busy_sb_empty", 128'(wr_q.size() + rd_q.size()), 128'(0));

    // Reset in the middle of unpacking aborts the job.
    fill(1);
    rd0 = rd_cnt;
    push_expected(4'd5, 4'd8);
    @(negedge clock);
    k_in = 4'd5; c_in = 4'd8; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (rd_cnt - rd0 >= 3) begin seen = 1'b1; break; end
    end
    chk("rst_mid_progress", 128'(seen), 128'(1));
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 128'(ready), 128'(1));
    chk("rst_mid_wr_en", 128'(wr_en), 128'(0));
    chk("rst_mid_rd_en", 128'(rd_en), 128'(0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("rst_hold_wr_en", 128'(wr_en), 128'(0));
    end
    wr_q.delete(); rd_q.delete();
    @(negedge clock);
    rst_n = 1'b1;
    wr0 = wr_cnt;
    repeat (5) @(negedge clock);
    chk("post_rst_ready", 128'(ready), 128'(1));
    chk("post_rst_no_writes", 128'(wr_cnt - wr0), 128'(0));

    // Start held high across the return to idle launches a second job.
    fill(1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_expected(4'd1, 4'd1);
    push_expected(4'd1, 4'd1);
    @(negedge clock);
    k_in = 4'd1; c_in = 4'd1; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rd_cnt - rd0 >= 2) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    chk("held_second_job", 128'(seen), 128'(1));
    wait_ready("held_done");
    chk("held_reads", 128'(rd_cnt - rd0), 128'(2));
    chk("held_writes", 128'(wr_cnt - wr0), 128'(2));
    chk("held_sb_empty", 128'(wr_q.size() + rd_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
